fare_calc: RTL and testbench



---
 rtl/fare_calc.sv | 134 +++++++++++++
 tb/tb_fare_calc.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/fare_calc.sv
// Fare accumulation stage: ride FSM, wheel-pulse distance count, per-minute waiting charge, timer enable.
// Ports: clk/sys_reset (async active-high); start/stop/clear pulses, wait_req level, async wheel_pulse, data_m minutes in;
//        timer_en, fare (0.1 units), distance (100 m units), state (0=IDLE 1=RUN 2=WAIT 3=DONE) out.
module fare_calc #(
    parameter int unsigned START_FARE   = 100,
    parameter int unsigned BASE_DIST    = 30,
    parameter int unsigned PER_100M     = 2,
    parameter int unsigned WAIT_PER_MIN = 10,
    parameter int unsigned FARE_MAX     = 9999,
    parameter int unsigned DIST_MAX     = 9999
) (
    input  logic        clk,
    input  logic        sys_reset,
    input  logic        start,
    input  logic        stop,
    input  logic        clear,
    input  logic        wait_req,
    input  logic        wheel_pulse,
    input  logic [7:0]  data_m,
    output logic        timer_en,
    output logic [15:0] fare,
    output logic [15:0] distance,
    output logic [1:0]  state
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [15:0] fare_q, fare_d;
    logic [15:0] dist_q, dist_d;
    logic        ten_q, ten_d;
    logic        w_s1_q, w_s2_q, w_s3_q;
    logic [7:0]  prev_m_q;

    logic        wheel_edge;
    logic        tick;
    logic [16:0] dist_inc;
    logic [15:0] dist_new;
    logic [16:0] fare_add;
    logic [16:0] fare_sum;

    // w_s1/w_s2 synchronise the wheel input; w_s3 is the previous synchronised value for edge detect.
    assign wheel_edge = w_s2_q & ~w_s3_q;
    // The timer only advances while enabled, so any change here is a genuine minute step (including 59->0).
    assign tick       = (data_m != prev_m_q);

    assign dist_inc = {1'b0, dist_q} + 17'd1;
    assign dist_new = (dist_inc > 17'(DIST_MAX)) ? 16'(DIST_MAX) : dist_inc[15:0];

    always_comb begin
        fare_add = 17'd0;
        if (wheel_edge && (dist_new > 16'(BASE_DIST))) begin
            fare_add = fare_add + 17'(PER_100M);
        end
        // Charged on the state held this cycle, so a WAIT->RUN transition still bills the tick.
        if (tick && (state_q == S_WAIT)) begin
            fare_add = fare_add + 17'(WAIT_PER_MIN);
        end
    end

    assign fare_sum = {1'b0, fare_q} + fare_add;

    always_comb begin
        state_d = state_q;
        fare_d  = fare_q;
        dist_d  = dist_q;
        case (state_q)
            S_IDLE: begin
                if (!stop && start) begin
                    state_d = S_RUN;
                    fare_d  = 16'(START_FARE);
                    dist_d  = 16'd0;
                end
            end
            S_RUN, S_WAIT: begin
                // stop freezes the totals: any increment arriving in the same cycle is dropped.
                if (stop) begin
                    state_d = S_DONE;
                end else begin
                    if (wheel_edge) begin
                        dist_d = dist_new;
                    end
                    fare_d  = (fare_sum > 17'(FARE_MAX)) ? 16'(FARE_MAX) : fare_sum[15:0];
                    state_d = wait_req ? S_WAIT : S_RUN;
                end
            end
            default: begin
                if (!stop) begin
                    if (clear) begin
                        state_d = S_IDLE;
                        fare_d  = 16'd0;
                        dist_d  = 16'd0;
                    end else if (start) begin
                        state_d = S_RUN;
                        fare_d  = 16'(START_FARE);
                        dist_d  = 16'd0;
                    end
                end
            end
        endcase
        ten_d = (state_d == S_WAIT);
    end

    always_ff @(posedge clk or posedge sys_reset) begin
        if (sys_reset) begin
            state_q  <= S_IDLE;
            fare_q   <= 16'd0;
            dist_q   <= 16'd0;
            ten_q    <= 1'b0;
            w_s1_q   <= 1'b0;
            w_s2_q   <= 1'b0;
            w_s3_q   <= 1'b0;
            prev_m_q <= 8'd0;
        end else begin
            state_q  <= state_d;
            fare_q   <= fare_d;
            dist_q   <= dist_d;
            ten_q    <= ten_d;
            w_s1_q   <= wheel_pulse;
            w_s2_q   <= w_s1_q;
            w_s3_q   <= w_s2_q;
            prev_m_q <= data_m;
        end
    end

    assign timer_en = ten_q;
    assign fare     = fare_q;
    assign distance = dist_q;
    assign state    = state_q;

endmodule

// File: tb/tb_fare_calc.sv
module tb_fare_calc;

    logic        clk = 1'b0;
    logic        sys_reset;
    logic        start, stop, clear, wait_req, wheel_pulse;
    logic [7:0]  data_m;
    logic        timer_en;
    logic [15:0] fare, distance;
    logic [1:0]  state;

    int n_pass  = 0;
    int n_total = 0;

    fare_calc dut (
        .clk(clk), .sys_reset(sys_reset), .start(start), .stop(stop), .clear(clear),
        .wait_req(wait_req), .wheel_pulse(wheel_pulse), .data_m(data_m),
        .timer_en(timer_en), .fare(fare), .distance(distance), .state(state)
    );

    always #5 clk = ~clk;

    // Reference model: ride rules applied per clock with plain integers.
    // A wheel rise driven after edge n is first seen by the model at edge n+1 and lands at edge n+3.
    int m_st, m_fare, m_dist, m_ten;
    int m_cyc, m_rise_at, m_last_m;
    logic m_last_w;

    always @(posedge clk or posedge sys_reset) begin
        int c, st, f, d, add;
        bit we, tk;
        if (sys_reset) begin
            m_st <= 0; m_fare <= 0; m_dist <= 0; m_ten <= 0;
            m_rise_at <= -10; m_last_m <= 0; m_last_w <= 1'b0;
        end else begin
            c   = m_cyc + 1;
            st  = m_st; f = m_fare; d = m_dist;
            we  = (m_rise_at == c - 2);
            tk  = (int'(data_m) != m_last_m);
            if (st == 0) begin
                if (!stop && start) begin st = 1; f = 100; d = 0; end
            end else if (st == 1 || st == 2) begin
                if (stop) st = 3;
                else begin
                    add = 0;
                    if (we) begin
                        d = (d + 1 > 9999) ? 9999 : d + 1;
                        if (d > 30) add += 2;
                    end
                    if (tk && st == 2) add += 10;
                    f  = (f + add > 9999) ? 9999 : f + add;
                    st = wait_req ? 2 : 1;
                end
            end else if (!stop) begin
                if (clear) begin st = 0; f = 0; d = 0; end
                else if (start) begin st = 1; f = 100; d = 0; end
            end
            m_st <= st; m_fare <= f; m_dist <= d; m_ten <= (st == 2) ? 1 : 0;
            if (wheel_pulse && !m_last_w) m_rise_at <= c;
            m_last_w <= wheel_pulse;
            m_last_m <= int'(data_m);
        end
    end

    always @(posedge clk) m_cyc <= m_cyc + 1;
    initial m_cyc = 0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Advance one clock and compare every output with the model, away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
        if (!sys_reset) begin
            check("model_state", int'(state), m_st);
            check("model_fare", int'(fare), m_fare);
            check("model_dist", int'(distance), m_dist);
            check("model_ten", int'(timer_en), m_ten);
        end
    endtask

    task automatic pulse_wheel();
        wheel_pulse = 1'b1; step(); step();
        wheel_pulse = 1'b0; step(); step();
    endtask

    initial begin
        sys_reset = 1'b1; start = 0; stop = 0; clear = 0; wait_req = 0; wheel_pulse = 0; data_m = 8'd0;
        repeat (2) @(posedge clk);
        #1 sys_reset = 1'b0;
        check("rst_state", int'(state), 0);
        check("rst_fare", int'(fare), 0);
        check("rst_dist", int'(distance), 0);
        check("rst_ten", int'(timer_en), 0);
        step();

        // 1. start a ride
        start = 1; step(); start = 0;
        check("start_state", int'(state), 1);
        check("start_fare", int'(fare), 100);
        check("start_dist", int'(distance), 0);
        check("start_ten", int'(timer_en), 0);

        // 2. wheel latency, then 35 pulses in total
        wheel_pulse = 1; step(); step();
        check("lat_dist_edge2", int'(distance), 0);
        wheel_pulse = 0; step();
        check("lat_dist_edge3", int'(distance), 1);
        step();
        for (int i = 0; i < 34; i++) pulse_wheel();
        check("run_dist35", int'(distance), 35);
        check("run_fare110", int'(fare), 110);

        // 3. waiting charge
        wait_req = 1; step();
        check("wait_state", int'(state), 2);
        check("wait_ten", int'(timer_en), 1);
        data_m = 8'd1; step();
        data_m = 8'd2; step();
        check("wait_fare130", int'(fare), 130);
        wait_req = 0; step();
        check("unwait_ten", int'(timer_en), 0);
        data_m = 8'd3; step();
        data_m = 8'd4; step();
        check("run_no_charge", int'(fare), 130);
        wait_req = 1; step();
        data_m = 8'd5; wait_req = 0; step();
        check("wait_exit_tick", int'(fare), 140);
        check("wait_exit_state", int'(state), 1);

        // 4. 59->0 wrap with coincident wheel edge
        wait_req = 1; step();
        data_m = 8'd59; step();
        check("tick59_fare", int'(fare), 150);
        wheel_pulse = 1; step(); step();
        data_m = 8'd0; wheel_pulse = 0; step();
        check("wrap_edge_fare", int'(fare), 162);
        check("wrap_edge_dist", int'(distance), 36);
        step(); step();

        // 5. stop coincident with wheel edge and tick, then clear+start
        wheel_pulse = 1; step(); step();
        stop = 1; wheel_pulse = 0; data_m = 8'd1; wait_req = 0; step(); stop = 0;
        check("stop_state", int'(state), 3);
        check("stop_fare", int'(fare), 162);
        check("stop_dist", int'(distance), 36);
        step(); step();
        check("done_hold_fare", int'(fare), 162);
        clear = 1; start = 1; step(); clear = 0; start = 0;
        check("clr_state", int'(state), 0);
        check("clr_fare", int'(fare), 0);
        check("clr_dist", int'(distance), 0);
        start = 1; step(); start = 0;
        clear = 1; step(); clear = 0;
        check("clear_in_run", int'(state), 1);
        check("clear_in_run_fare", int'(fare), 100);

        // 6. saturation via repeated charged ticks, then async reset mid-WAIT
        wait_req = 1; step();
        for (int i = 0; i < 989; i++) begin
            data_m = (data_m == 8'd59) ? 8'd0 : data_m + 8'd1;
            step();
        end
        check("near_cap_fare", int'(fare), 9990);
        data_m = (data_m == 8'd59) ? 8'd0 : data_m + 8'd1; step();
        check("cap_fare", int'(fare), 9999);
        for (int i = 0; i < 3; i++) begin
            data_m = (data_m == 8'd59) ? 8'd0 : data_m + 8'd1;
            step();
        end
        check("cap_hold", int'(fare), 9999);
        check("cap_state", int'(state), 2);
        #2 sys_reset = 1;
        #1;
        check("arst_state", int'(state), 0);
        check("arst_fare", int'(fare), 0);
        check("arst_dist", int'(distance), 0);
        check("arst_ten", int'(timer_en), 0);
        @(posedge clk); #1 sys_reset = 0;
        wait_req = 0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
